reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 35 +++
 rtl/bit_sync.sv | 38 +++
 rtl/reset_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq_pkg
//  Description : Shared state encoding and sizing helpers for the staged
//                reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ASSERT_ALL = 2'd0,
      WAIT_LOCK  = 2'd1,
      RELEASE    = 2'd2,
      RUN        = 2'd3
   } rseq_state_t;

   // Width of the hold/filter counters: wide enough to hold the larger of
   // the two thresholds, never less than one bit.
   function automatic int cnt_width(input int hold, input int filt);
      int m;
      int w;
      m = (hold > filt) ? hold : filt;
      w = $clog2(m + 1);
      return (w < 1) ? 1 : w;
   endfunction

   // Width of the stage index, never less than one bit.
   function automatic int idx_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
//  Module      : bit_sync
//  Description : Multi-flop synchronizer for a single asynchronous level.
//                Resets to 0 so a lock flag reads as "not locked" until it
//                has been seen high after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the asynchronous input one flop further down the chain.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   // Synchronizer chain, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Holds all downstream resets, waits for a filtered PLL lock,
//                then releases the staged resets one at a time with a fixed
//                spacing. Lock loss or a soft request restarts the sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES   = 4,
   parameter int HOLD_CYCLES  = 16,
   parameter int LOCK_FILTER  = 8,
   parameter int OUT_POLARITY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pll_locked,
   input  logic                  soft_rst_req,
   output logic                  soft_rst_ack,
   output logic [NUM_STAGES-1:0] stage_rst,
   output logic                  all_released
);

   localparam int CNT_W = cnt_width(HOLD_CYCLES, LOCK_FILTER);
   localparam int IDX_W = idx_width(NUM_STAGES);

   localparam logic [CNT_W-1:0]      HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]      FILT_DONE    = CNT_W'(LOCK_FILTER);
   localparam logic [IDX_W-1:0]      IDX_LAST     = IDX_W'(NUM_STAGES - 1);
   localparam logic [NUM_STAGES-1:0] ALL_ASSERTED = {NUM_STAGES{OUT_POLARITY == 0}};

   logic lock_s;

   rseq_state_t            state_q,        state_d;
   logic [CNT_W-1:0]       hold_cnt_q,     hold_cnt_d;
   logic [CNT_W-1:0]       filt_cnt_q,     filt_cnt_d;
   logic [IDX_W-1:0]       idx_q,          idx_d;
   // One bit per stage, 1 = released; polarity is applied only at the output.
   logic [NUM_STAGES-1:0]  rel_q,          rel_d;
   logic [NUM_STAGES-1:0]  stage_rst_q,    stage_rst_d;
   logic                   all_released_q, all_released_d;
   logic                   ack_q,          ack_d;

   bit_sync #(
      .STAGES (2)
   ) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lock_s)
   );

   // Next-state and next-output computation for the sequencer.
   always_comb begin
      state_d        = state_q;
      hold_cnt_d     = hold_cnt_q;
      filt_cnt_d     = filt_cnt_q;
      idx_d          = idx_q;
      rel_d          = rel_q;
      all_released_d = all_released_q;
      ack_d          = 1'b0;

      if (soft_rst_req) begin
         // A request wins over everything except rst, including lock loss.
         state_d        = ASSERT_ALL;
         hold_cnt_d     = '0;
         filt_cnt_d     = '0;
         idx_d          = '0;
         rel_d          = '0;
         all_released_d = 1'b0;
         ack_d          = 1'b1;
      end else begin
         case (state_q)
            ASSERT_ALL: begin
               rel_d          = '0;
               all_released_d = 1'b0;
               if (hold_cnt_q >= HOLD_LAST) begin
                  state_d    = WAIT_LOCK;
                  hold_cnt_d = '0;
                  filt_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end

            WAIT_LOCK: begin
               if (!lock_s) begin
                  filt_cnt_d = '0;
               end else if (filt_cnt_q >= FILT_DONE) begin
                  // Stage 0 is released on the same edge the filter completes.
                  rel_d      = '0;
                  rel_d[0]   = 1'b1;
                  idx_d      = '0;
                  hold_cnt_d = '0;
                  filt_cnt_d = '0;
                  if (IDX_LAST == '0) begin
                     state_d        = RUN;
                     all_released_d = 1'b1;
                  end else begin
                     state_d = RELEASE;
                  end
               end else begin
                  filt_cnt_d = filt_cnt_q + 1'b1;
               end
            end

            RELEASE: begin
               if (!lock_s) begin
                  state_d        = ASSERT_ALL;
                  hold_cnt_d     = '0;
                  idx_d          = '0;
                  rel_d          = '0;
                  all_released_d = 1'b0;
               end else if (hold_cnt_q >= HOLD_LAST) begin
                  hold_cnt_d   = '0;
                  idx_d        = idx_q + 1'b1;
                  rel_d[idx_d] = 1'b1;
                  if (idx_d == IDX_LAST) begin
                     state_d        = RUN;
                     all_released_d = 1'b1;
                  end
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end

            RUN: begin
               if (!lock_s) begin
                  state_d        = ASSERT_ALL;
                  hold_cnt_d     = '0;
                  idx_d          = '0;
                  rel_d          = '0;
                  all_released_d = 1'b0;
               end
            end

            default: begin
               state_d        = ASSERT_ALL;
               hold_cnt_d     = '0;
               filt_cnt_d     = '0;
               idx_d          = '0;
               rel_d          = '0;
               all_released_d = 1'b0;
            end
         endcase
      end

      stage_rst_d = (OUT_POLARITY == 0) ? ~rel_d : rel_d;
   end

   // State, counters and registered outputs; rst overrides any request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ASSERT_ALL;
         hold_cnt_q     <= '0;
         filt_cnt_q     <= '0;
         idx_q          <= '0;
         rel_q          <= '0;
         stage_rst_q    <= ALL_ASSERTED;
         all_released_q <= 1'b0;
         ack_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         hold_cnt_q     <= hold_cnt_d;
         filt_cnt_q     <= filt_cnt_d;
         idx_q          <= idx_d;
         rel_q          <= rel_d;
         stage_rst_q    <= stage_rst_d;
         all_released_q <= all_released_d;
         ack_q          <= ack_d;
      end
   end

   assign stage_rst    = stage_rst_q;
   assign all_released = all_released_q;
   assign soft_rst_ack = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Directed bench for reset_sequencer with NUM_STAGES=3,
//                HOLD_CYCLES=4, LOCK_FILTER=2. Two instances share stimulus,
//                one active-high and one active-low. E0 is the first edge at
//                which rst is sampled low.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

   localparam int N  = 3;
   localparam int H  = 4;
   localparam int LF = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         pll_locked;
   logic         soft_rst_req;
   logic         ack0, ack1;
   logic         all0, all1;
   logic [N-1:0] st0, st1;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int e0       = 0;
   int t        = 0;
   logic track_ack = 1'b0;
   logic ack_seen  = 1'b0;

   always #5 clk = ~clk;

   reset_sequencer #(
      .NUM_STAGES(N), .HOLD_CYCLES(H), .LOCK_FILTER(LF), .OUT_POLARITY(0)
   ) u_dut_hi (
      .clk(clk), .rst(rst), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
      .soft_rst_ack(ack0), .stage_rst(st0), .all_released(all0)
   );

   reset_sequencer #(
      .NUM_STAGES(N), .HOLD_CYCLES(H), .LOCK_FILTER(LF), .OUT_POLARITY(1)
   ) u_dut_lo (
      .clk(clk), .rst(rst), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
      .soft_rst_ack(ack1), .stage_rst(st1), .all_released(all1)
   );

   // Remember any ack seen while tracking is enabled.
   always @(negedge clk) begin
      if (track_ack && (ack0 || ack1)) ack_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) tick();
   endtask

   // exp is in active-high terms (1 = asserted); the active-low copy is inverted.
   task automatic chk_stage(input string tag, input logic [N-1:0] exp);
      logic [N-1:0] inv;
      inv = ~exp;
      check({tag, "_hi"}, st0, exp);
      check({tag, "_lo"}, st1, inv);
   endtask

   task automatic chk_rel(input string tag, input logic exp);
      check({tag, "_rel_hi"}, all0, exp);
      check({tag, "_rel_lo"}, all1, exp);
   endtask

   task automatic do_reset(input logic lock);
      rst          = 1'b1;
      pll_locked   = lock;
      soft_rst_req = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      e0  = cyc + 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      pll_locked   = 1'b0;
      soft_rst_req = 1'b0;

      // Power-up with lock held high throughout.
      do_reset(1'b1);
      chk_stage("rst_stage", 3'b111);
      chk_rel("rst", 1'b0);
      check("rst_ack_hi", ack0, 1'b0);
      check("rst_ack_lo", ack1, 1'b0);
      track_ack = 1'b1;
      run_to(e0 + 5);  chk_stage("pu_e5",  3'b111);
      run_to(e0 + 6);  chk_stage("pu_e6",  3'b110);
      run_to(e0 + 9);  chk_stage("pu_e9",  3'b110);
      run_to(e0 + 10); chk_stage("pu_e10", 3'b100);
      run_to(e0 + 13); chk_stage("pu_e13", 3'b100); chk_rel("pu_e13", 1'b0);
      run_to(e0 + 14); chk_stage("pu_e14", 3'b000); chk_rel("pu_e14", 1'b1);
      run_to(e0 + 16);
      track_ack = 1'b0;
      check("pu_no_ack", ack_seen, 1'b0);

      // One-cycle lock glitch during the filter restarts it.
      do_reset(1'b0);
      run_to(e0 + 9);  pll_locked = 1'b1;
      run_to(e0 + 11); pll_locked = 1'b0;
      tick();          pll_locked = 1'b1;
      run_to(e0 + 14); chk_stage("gl_e14", 3'b111);
      run_to(e0 + 16); chk_stage("gl_e16", 3'b111);
      run_to(e0 + 17); chk_stage("gl_e17", 3'b110);

      // Late lock: sampled high at E0+20, release four edges later.
      do_reset(1'b0);
      run_to(e0 + 19); pll_locked = 1'b1;
      run_to(e0 + 23); chk_stage("lk_e23", 3'b111);
      run_to(e0 + 24); chk_stage("lk_e24", 3'b110);
      run_to(e0 + 28); chk_stage("lk_e28", 3'b100);
      run_to(e0 + 32); chk_stage("lk_e32", 3'b000); chk_rel("lk_e32", 1'b1);

      // Lock loss in RUN, then relock replays the sequence.
      run_to(e0 + 34); pll_locked = 1'b0;
      run_to(e0 + 36); chk_stage("ll_e36", 3'b000); chk_rel("ll_e36", 1'b1);
      run_to(e0 + 37); chk_stage("ll_e37", 3'b111); chk_rel("ll_e37", 1'b0);
      check("ll_ack", ack0, 1'b0);
      pll_locked = 1'b1;
      run_to(e0 + 43); chk_stage("rl_e43", 3'b111);
      run_to(e0 + 44); chk_stage("rl_e44", 3'b110);
      run_to(e0 + 48); chk_stage("rl_e48", 3'b100);
      run_to(e0 + 52); chk_stage("rl_e52", 3'b000); chk_rel("rl_e52", 1'b1);

      // Soft request in RUN, sampled at edge t; second request at t+3.
      t = cyc + 2;
      run_to(t - 1); soft_rst_req = 1'b1;
      tick();        soft_rst_req = 1'b0;
      check("sr_ack_hi", ack0, 1'b1);
      check("sr_ack_lo", ack1, 1'b1);
      chk_stage("sr_t0", 3'b111);
      chk_rel("sr_t0", 1'b0);
      run_to(t + 1); check("sr_ack_drop", ack0, 1'b0);
      run_to(t + 2); soft_rst_req = 1'b1;
      tick();        soft_rst_req = 1'b0;
      check("sr2_ack", ack0, 1'b1);
      run_to(t + 4);  check("sr2_ack_drop", ack0, 1'b0);
      run_to(t + 7);  chk_stage("sr2_t7", 3'b111);
      run_to(t + 9);  chk_stage("sr2_t9", 3'b111);
      run_to(t + 10); chk_stage("sr2_t10", 3'b110);

      // rst and soft request together mid-RELEASE: rst wins, no ack.
      run_to(t + 11);
      rst = 1'b1; soft_rst_req = 1'b1;
      tick();
      check("rr_ack_hi", ack0, 1'b0);
      check("rr_ack_lo", ack1, 1'b0);
      chk_stage("rr_stage", 3'b111);
      chk_rel("rr", 1'b0);
      rst = 1'b0; soft_rst_req = 1'b0;
      e0 = cyc + 1;
      run_to(e0 + 5);  chk_stage("rr_e5",  3'b111);
      run_to(e0 + 6);  chk_stage("rr_e6",  3'b110);
      run_to(e0 + 10); chk_stage("rr_e10", 3'b100);
      run_to(e0 + 14); chk_stage("rr_e14", 3'b000); chk_rel("rr_e14", 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
